// File: rtl/pll_rst_sequencer_if.sv
// Control and status bundle between the PLL/reset sequencer and the clock generator and memory-controller side.
// pll_locked is asynchronous to clk; every other signal is synchronous to the sequencer clock.
interface pll_rst_sequencer_if;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  modport master (
    output pll_locked, restart_req,
    input  pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
  );

  modport slave (
    input  pll_locked, restart_req,
    output pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt
  );
endinterface

// File: rtl/pll_rst_sequencer.sv
// PLL/DCM bring-up sequencer: pulses the PLL reset, waits for a stable lock with timeout and bounded retries,
// then releases the memory-controller reset and re-sequences if lock is lost while running.
module pll_rst_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT     = 4096,
  parameter int unsigned STABLE_CYCLES    = 256,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input logic                 clk,
  input logic                 rst,
  pll_rst_sequencer_if.slave  bus
);

  localparam int unsigned MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CNT = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int          CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lost_d;
  logic             meta_q, lk_q;
  logic             pll_rst_q, sys_rst_q, ready_q, fail_q, lock_lost_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    // A restart request overrides every state-local condition in the same cycle.
    if (bus.restart_req) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lk_q) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABILIZE: begin
          // A lock glitch restarts the stability window but does not count as a failed attempt.
          if (!lk_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lk_q) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      meta_q      <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      meta_q      <= bus.pll_locked;
      lk_q        <= meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_q   <= (state_d != S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
      lock_lost_q <= lost_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: directed scenarios with literal expectations plus randomized lock/restart traffic,
// all checked each cycle against a timestamp-based phase model of the sequencing rules.
module tb_pll_rst_sequencer;
  localparam int RP = 4;
  localparam int TO = 16;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAIL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_rst_sequencer_if bus();

  pll_rst_sequencer #(
    .RST_PULSE_CYCLES(RP),
    .LOCK_TIMEOUT    (TO),
    .STABLE_CYCLES   (SC),
    .MAX_RETRIES     (MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: current phase, cycle index, cycle the phase was entered, failed-attempt count, synchroniser history.
  int cyc, t0, ph, att;
  bit lost, m_meta, m_lk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; t0 = 0; ph = P_PULSE; att = 0; lost = 0; m_meta = 0; m_lk = 0;
  endtask

  task automatic model_step();
    bit lk;
    int el;
    lk   = m_lk;
    el   = cyc - t0;
    lost = 0;
    cyc++;
    if (bus.restart_req) begin
      ph = P_PULSE; t0 = cyc; att = 0;
    end else begin
      case (ph)
        P_PULSE: if (el == RP - 1) begin ph = P_WAIT; t0 = cyc; end
        P_WAIT: begin
          if (lk) begin
            ph = P_STAB; t0 = cyc;
          end else if (el == TO - 1) begin
            t0 = cyc;
            if (att == MR) ph = P_FAIL;
            else begin att++; ph = P_PULSE; end
          end
        end
        P_STAB: begin
          if (!lk) begin ph = P_WAIT; t0 = cyc; end
          else if (el == SC - 1) begin ph = P_RUN; t0 = cyc; end
        end
        P_RUN: if (!lk) begin ph = P_PULSE; t0 = cyc; att = 0; lost = 1; end
        default: ;
      endcase
    end
    m_lk   = m_meta;
    m_meta = bus.pll_locked;
  endtask

  task automatic compare_all();
    chk("pll_rst",   4'(bus.pll_rst),   4'(ph == P_PULSE || ph == P_FAIL));
    chk("sys_rst",   4'(bus.sys_rst),   4'(ph != P_RUN));
    chk("ready",     4'(bus.ready),     4'(ph == P_RUN));
    chk("fail",      4'(bus.fail),      4'(ph == P_FAIL));
    chk("lock_lost", 4'(bus.lock_lost), 4'(lost));
    chk("retry_cnt", bus.retry_cnt,     4'(att));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   4'(bus.pll_rst),   4'd1);
    chk({tag, "_sys_rst"},   4'(bus.sys_rst),   4'd1);
    chk({tag, "_ready"},     4'(bus.ready),     4'd0);
    chk({tag, "_fail"},      4'(bus.fail),      4'd0);
    chk({tag, "_lock_lost"}, 4'(bus.lock_lost), 4'd0);
    chk({tag, "_retry"},     bus.retry_cnt,     4'd0);
  endtask

  task automatic do_reset(input logic lock);
    rst             = 1'b1;
    bus.pll_locked  = lock;
    bus.restart_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int hold;
    bus.pll_locked  = 1'b0;
    bus.restart_req = 1'b0;

    // Lock arrives at cycle 10: lk at 12, STABILIZE at 13, RUN 8 cycles later at 21.
    do_reset(1'b0);
    run_to(3);  chk("t1_pulse_c3", 4'(bus.pll_rst), 4'd1);
    run_to(4);  chk("t1_wait_c4",  4'(bus.pll_rst), 4'd0);
    run_to(10); bus.pll_locked = 1'b1;
    run_to(20); chk("t1_ready_c20", 4'(bus.ready), 4'd0);
    run_to(21); chk("t1_ready_c21", 4'(bus.ready), 4'd1);
    chk("t1_sysrst_c21", 4'(bus.sys_rst), 4'd0);
    chk("t1_retry_c21",  bus.retry_cnt, 4'd0);

    // No lock: attempts of 4+16 cycles, retries at 20 and 40, FAIL at 60.
    do_reset(1'b0);
    run_to(19); chk("t2_retry_c19", bus.retry_cnt, 4'd0);
    run_to(20); chk("t2_retry_c20", bus.retry_cnt, 4'd1);
    chk("t2_pllrst_c20", 4'(bus.pll_rst), 4'd1);
    run_to(40); chk("t2_retry_c40", bus.retry_cnt, 4'd2);
    run_to(59); chk("t2_fail_c59", 4'(bus.fail), 4'd0);
    run_to(60); chk("t2_fail_c60", 4'(bus.fail), 4'd1);
    chk("t2_pllrst_c60", 4'(bus.pll_rst), 4'd1);
    chk("t2_sysrst_c60", 4'(bus.sys_rst), 4'd1);
    run_to(120); chk("t2_fail_c120", 4'(bus.fail), 4'd1);

    // Restart out of FAIL, then lock.
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    chk("t3_fail_clr",  4'(bus.fail), 4'd0);
    chk("t3_retry_clr", bus.retry_cnt, 4'd0);
    chk("t3_pllrst",    4'(bus.pll_rst), 4'd1);
    bus.pll_locked = 1'b1;
    repeat (25) tick();
    chk("t3_ready", 4'(bus.ready), 4'd1);

    // One-cycle lock drop lands on stable count 5 (cycle 10); fresh window gives RUN at 20.
    do_reset(1'b1);
    run_to(8);  bus.pll_locked = 1'b0;
    run_to(9);  bus.pll_locked = 1'b1;
    run_to(13); chk("t4_ready_c13", 4'(bus.ready), 4'd0);
    run_to(19); chk("t4_ready_c19", 4'(bus.ready), 4'd0);
    chk("t4_retry_c19", bus.retry_cnt, 4'd0);
    run_to(20); chk("t4_ready_c20", 4'(bus.ready), 4'd1);

    // Lock loss in RUN at cycle 30: detected at 33, re-lock gives RUN at 46.
    run_to(30); bus.pll_locked = 1'b0;
    run_to(33); bus.pll_locked = 1'b1;
    chk("t5_lost_c33",   4'(bus.lock_lost), 4'd1);
    chk("t5_sysrst_c33", 4'(bus.sys_rst), 4'd1);
    chk("t5_ready_c33",  4'(bus.ready), 4'd0);
    chk("t5_pllrst_c33", 4'(bus.pll_rst), 4'd1);
    run_to(34); chk("t5_lost_c34",   4'(bus.lock_lost), 4'd0);
    run_to(36); chk("t5_pllrst_c36", 4'(bus.pll_rst), 4'd1);
    run_to(37); chk("t5_pllrst_c37", 4'(bus.pll_rst), 4'd0);
    run_to(45); chk("t5_ready_c45",  4'(bus.ready), 4'd0);
    run_to(46); chk("t5_ready_c46",  4'(bus.ready), 4'd1);

    // Asynchronous reset mid-WAIT_LOCK with one retry used.
    do_reset(1'b0);
    run_to(25); chk("t6_retry_c25", bus.retry_cnt, 4'd1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("t6_async");
    do_reset(1'b0);
    // Restart in the very cycle the first attempt times out.
    run_to(19);
    bus.restart_req = 1'b1;
    tick();
    bus.restart_req = 1'b0;
    chk("t6_restart_retry", bus.retry_cnt, 4'd0);
    chk("t6_restart_pll",   4'(bus.pll_rst), 4'd1);
    run_to(23); chk("t6_pulse_c23", 4'(bus.pll_rst), 4'd1);
    run_to(24); chk("t6_pulse_c24", 4'(bus.pll_rst), 4'd0);

    // Randomized lock waveform with occasional restarts.
    do_reset(1'b0);
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        bus.pll_locked = ~bus.pll_locked;
        hold = bus.pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 25));
      end
      hold--;
      bus.restart_req = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.restart_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
